// File: rtl/trng_pkg.sv
// Shared types and width helpers for the TRNG bias calibrator.
package trng_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SETTLE     = 3'd1,
        ST_MEASURE    = 3'd2,
        ST_SAR_EVAL   = 3'd3,
        ST_TRACK_EVAL = 3'd4
    } state_e;

    typedef enum logic {
        MODE_SAR   = 1'b0,
        MODE_TRACK = 1'b1
    } mode_e;

    function automatic int unsigned midscale(input int unsigned bw);
        return 32'd1 << (bw - 1);
    endfunction

    // Counter width able to hold 0..n-1 (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/trng_bias_cal_if.sv
// Sample, control and VDAC signal bundle between the calibrator and its surroundings.
interface trng_bias_cal_if #(
    parameter int unsigned BITWIDTH = 6,
    parameter int unsigned WIN_LOG2 = 10
);
    logic                i_bit;
    logic                i_start;
    logic [WIN_LOG2:0]   i_target;
    logic [WIN_LOG2:0]   i_tol;
    logic [BITWIDTH-1:0] o_vdac_data;
    logic                o_vdac_enable;
    logic                o_busy;
    logic                o_locked;
    logic [WIN_LOG2:0]   o_ones;
    logic                o_ones_valid;

    modport slave (
        input  i_bit, i_start, i_target, i_tol,
        output o_vdac_data, o_vdac_enable, o_busy, o_locked, o_ones, o_ones_valid
    );

    modport master (
        output i_bit, i_start, i_target, i_tol,
        input  o_vdac_data, o_vdac_enable, o_busy, o_locked, o_ones, o_ones_valid
    );
endinterface

// File: rtl/trng_window_counter.sv
// Counts ones over a 2^WIN_LOG2 sample window; total includes the current sample.
module trng_window_counter #(
    parameter int unsigned WIN_LOG2 = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              sample,
    output logic              done,
    output logic [WIN_LOG2:0] total
);

    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [WIN_LOG2:0]   acc_q, acc_d;

    always_comb begin
        total = acc_q + {{WIN_LOG2{1'b0}}, sample};
        done  = !clear && (cnt_q == '1);
        if (clear) begin
            cnt_d = '0;
            acc_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
            acc_d = total;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/trng_bias_cal.sv
// Closed-loop VDAC bias calibrator: SAR search on the ones-density, then +/-1 tracking.
module trng_bias_cal
    import trng_pkg::*;
#(
    parameter int unsigned BITWIDTH   = 6,
    parameter int unsigned WIN_LOG2   = 10,
    parameter int unsigned SETTLE_CYC = 16
) (
    input  logic           clk,
    input  logic           rst,
    trng_bias_cal_if.slave bus
);

    localparam int unsigned CW = WIN_LOG2 + 1;
    localparam int unsigned IW = cnt_w(BITWIDTH);
    localparam int unsigned SW = cnt_w(SETTLE_CYC);
    localparam logic [BITWIDTH-1:0] MID         = BITWIDTH'(midscale(BITWIDTH));
    localparam logic [SW-1:0]       SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [CW:0]         WIN_MAX     = {2'b01, {WIN_LOG2{1'b0}}};

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [BITWIDTH-1:0] code_q, code_d;
    logic                en_q, en_d;
    logic                busy_q, busy_d;
    logic                locked_q, locked_d;
    logic [CW-1:0]       ones_q, ones_d;
    logic                valid_q, valid_d;
    logic [SW-1:0]       settle_q, settle_d;

    logic                win_done;
    logic [CW-1:0]       win_total;
    logic [CW-1:0]       lo_bnd, hi_bnd;
    logic [CW:0]         hi_sum;
    logic [BITWIDTH-1:0] code_sar, code_inc, code_dec;

    trng_window_counter #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_win (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != ST_MEASURE),
        .sample (bus.i_bit),
        .done   (win_done),
        .total  (win_total)
    );

    // Dead-band edges clamp instead of wrapping: floor at 0, cap at a full window.
    always_comb begin
        lo_bnd = (bus.i_target > bus.i_tol) ? (bus.i_target - bus.i_tol) : '0;
        hi_sum = {1'b0, bus.i_target} + {1'b0, bus.i_tol};
        hi_bnd = (hi_sum > WIN_MAX) ? WIN_MAX[CW-1:0] : hi_sum[CW-1:0];
    end

    always_comb begin
        code_sar = code_q;
        if (ones_q >= bus.i_target) code_sar[idx_q] = 1'b0;
        if (idx_q != '0) code_sar[idx_q - 1'b1] = 1'b1;
        code_inc = (code_q == '1) ? code_q : code_q + 1'b1;
        code_dec = (code_q == '0) ? code_q : code_q - 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        idx_d    = idx_q;
        code_d   = code_q;
        locked_d = locked_q;
        ones_d   = ones_q;
        valid_d  = 1'b0;
        settle_d = '0;

        case (state_q)
            ST_IDLE: ;
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) state_d = ST_MEASURE;
                else settle_d = settle_q + 1'b1;
            end
            ST_MEASURE: begin
                if (win_done) begin
                    ones_d  = win_total;
                    valid_d = 1'b1;
                    state_d = (mode_q == MODE_SAR) ? ST_SAR_EVAL : ST_TRACK_EVAL;
                end
            end
            ST_SAR_EVAL: begin
                code_d  = code_sar;
                state_d = ST_SETTLE;
                if (idx_q != '0) idx_d = idx_q - 1'b1;
                else mode_d = MODE_TRACK;
            end
            ST_TRACK_EVAL: begin
                if (ones_q < lo_bnd) code_d = code_inc;
                else if (ones_q > hi_bnd) code_d = code_dec;
                locked_d = (ones_q >= lo_bnd) && (ones_q <= hi_bnd);
                state_d  = (code_d != code_q) ? ST_SETTLE : ST_MEASURE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A start overrides everything except an SAR search already in flight.
        if (bus.i_start && (state_q == ST_IDLE || mode_q == MODE_TRACK)) begin
            state_d  = ST_SETTLE;
            settle_d = '0;
            mode_d   = MODE_SAR;
            idx_d    = IW'(BITWIDTH - 1);
            code_d   = MID;
            locked_d = 1'b0;
            ones_d   = ones_q;
            valid_d  = 1'b0;
        end

        en_d   = (state_d != ST_IDLE);
        busy_d = (mode_d == MODE_SAR) &&
                 (state_d inside {ST_SETTLE, ST_MEASURE, ST_SAR_EVAL});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_SAR;
            idx_q    <= IW'(BITWIDTH - 1);
            code_q   <= MID;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
            ones_q   <= '0;
            valid_q  <= 1'b0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            idx_q    <= idx_d;
            code_q   <= code_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            locked_q <= locked_d;
            ones_q   <= ones_d;
            valid_q  <= valid_d;
            settle_q <= settle_d;
        end
    end

    assign bus.o_vdac_data   = code_q;
    assign bus.o_vdac_enable = en_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_locked      = locked_q;
    assign bus.o_ones        = ones_q;
    assign bus.o_ones_valid  = valid_q;

endmodule
